// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA definitions: source-mode encodings, colour-bar palette and
// default 640x480@60 timing; further resolutions add parameter sets here.
package vga_timing_gen_pkg;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_EXT   = 2'd2;

  localparam int NUM_BARS = 8;
  // {r[2:0],g[2:0],b[1:0]}: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [7:0] BAR_RGB [NUM_BARS] = '{
    8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00
  };

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: wrapping position counter with a registered visible-area flag
// and a sync level decoded from the current count.
module vga_axis_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FP     = VGA640_H_FP,
  parameter int SYNC   = VGA640_H_SYNC,
  parameter int BP     = VGA640_H_BP,
  parameter bit POL    = 1'b0,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic         wrap,
  output logic [W-1:0] count,
  output logic         active,
  output logic         sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_LAST = W'(ACTIVE - 1);
  localparam logic [W-1:0] SYNC_LO  = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI  = W'(ACTIVE + FP + SYNC - 1);

  logic [W-1:0] count_next;

  assign wrap = (count == LAST);
  assign sync = ((count >= SYNC_LO) && (count <= SYNC_HI)) ? POL : ~POL;

  // Next position along the axis
  always_comb begin
    count_next = count;
    if (wrap) begin
      count_next = {W{1'b0}};
    end else begin
      count_next = count + W'(1);
    end
  end

  // Reset parks the counter on its last position so the first enable lands on 0;
  // the visible flag is taken from the next count to stay aligned with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= LAST;
      active <= 1'b0;
    end else if (enable) begin
      count  <= count_next;
      active <= (count_next <= ACT_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a one-pixel output stage driving
// sync and RGB from a solid colour, colour bars or external pixel data.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_stb,
  input  logic [1:0]    mode,
  input  logic [7:0]    solid_rgb,
  input  logic [7:0]    ext_rgb,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic [2:0]    vga_r,
  output logic [2:0]    vga_g,
  output logic [1:0]    vga_b
);

  localparam int BAR_W = H_ACTIVE / NUM_BARS;

  logic       h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;
  logic       v_enable;
  logic [1:0] mode_q;
  logic [7:0] rgb_s;
  logic [7:0] rgb_r;

  // Remainder pixels past the eighth bar boundary stay on bar 7
  function automatic logic [2:0] bar_index(input logic [XW-1:0] xc);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < NUM_BARS; i++) begin
      if (xc >= XW'(i * BAR_W)) idx = 3'(i);
    end
    return idx;
  endfunction

  assign v_enable = pix_stb & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(XW)
  ) u_h_axis (
    .clk(clk), .rst(rst), .enable(pix_stb),
    .wrap(h_wrap), .count(x), .active(h_active), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(YW)
  ) u_v_axis (
    .clk(clk), .rst(rst), .enable(v_enable),
    .wrap(v_wrap), .count(y), .active(v_active), .sync(v_sync)
  );

  assign active = h_active & v_active;

  // Stage-0 strobes (a wrap now means the next x is 0) and per-frame mode latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      mode_q      <= MODE_SOLID;
    end else if (pix_stb) begin
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
      if (h_wrap && v_wrap) mode_q <= mode;
    end
  end

  // Pixel source selection for the stage-0 position
  always_comb begin
    rgb_s = 8'h00;
    if (!active) begin
      rgb_s = 8'h00;
    end else begin
      case (mode_q)
        MODE_SOLID: rgb_s = solid_rgb;
        MODE_BARS:  rgb_s = BAR_RGB[bar_index(x)];
        MODE_EXT:   rgb_s = ext_rgb;
        default:    rgb_s = 8'h00;
      endcase
    end
  end

  // Stage-1 output registers, one pixel behind the counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_hs <= ~HS_POL;
      vga_vs <= ~VS_POL;
      rgb_r  <= 8'h00;
    end else if (pix_stb) begin
      vga_hs <= h_sync;
      vga_vs <= v_sync;
      rgb_r  <= rgb_s;
    end
  end

  assign vga_r = rgb_r[7:5];
  assign vga_g = rgb_r[4:2];
  assign vga_b = rgb_r[1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing, plus a
// small-raster instance (active-high hs) for whole-frame behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

  // Instance A: default timing
  logic       rst_a, stb_a;
  logic [1:0] mode_a;
  logic [7:0] solid_a, ext_a, rgb_a;
  logic [9:0] x_a, y_a;
  logic       act_a, ls_a, fs_a, hs_a, vs_a;
  logic [2:0] r_a, g_a;
  logic [1:0] b_a;
  assign ext_a = x_a[7:0];
  assign rgb_a = {r_a, g_a, b_a};

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .pix_stb(stb_a), .mode(mode_a),
    .solid_rgb(solid_a), .ext_rgb(ext_a), .x(x_a), .y(y_a),
    .active(act_a), .line_start(ls_a), .frame_start(fs_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  // Instance B: 42+4+8+4 = 58 pixels, 6+2+2+2 = 12 lines, 696 strobes/frame
  logic       rst_b, stb_b;
  logic [1:0] mode_b;
  logic [7:0] solid_b, ext_b, rgb_b;
  logic [5:0] x_b;
  logic [3:0] y_b;
  logic       act_b, ls_b, fs_b, hs_b, vs_b;
  logic [2:0] r_b, g_b;
  logic [1:0] b_b;
  assign ext_b = {2'b00, x_b};
  assign rgb_b = {r_b, g_b, b_b};

  vga_timing_gen #(
    .H_ACTIVE(42), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b0), .XW(6), .YW(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .pix_stb(stb_b), .mode(mode_b),
    .solid_rgb(solid_b), .ext_rgb(ext_b), .x(x_b), .y(y_b),
    .active(act_b), .line_start(ls_b), .frame_start(fs_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic sa, input logic sb);
    stb_a = sa;
    stb_b = sb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_lo, n_e0, n_zero, n, vs_lo, hs_hi, n_solid, n_ls;
    bit got_fs;
    int idx;

    rst_a = 1'b0; rst_b = 1'b0; stb_a = 1'b0; stb_b = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0; solid_a = 8'hE0; solid_b = 8'h1C;

    repeat (3) tick(1'b1, 1'b1);
    check("a_rst_x", x_a, 799);
    check("a_rst_y", y_a, 524);
    check("a_rst_active", act_a, 0);
    check("a_rst_ls", ls_a, 0);
    check("a_rst_fs", fs_a, 0);
    check("a_rst_hs", hs_a, 1);
    check("a_rst_vs", vs_a, 1);
    check("a_rst_rgb", rgb_a, 0);
    check("b_rst_x", x_b, 57);
    check("b_rst_y", y_b, 11);
    check("b_rst_hs", hs_b, 0);
    check("b_rst_vs", vs_b, 1);
    check("b_rst_active", act_b, 0);

    // First strobe after release lands on (0,0)
    rst_a = 1'b1;
    tick(1'b1, 1'b0);
    check("a_first_x", x_a, 0);
    check("a_first_y", y_a, 0);
    check("a_first_fs", fs_a, 1);
    check("a_first_ls", ls_a, 1);
    check("a_first_active", act_a, 1);
    check("a_first_rgb", rgb_a, 0);

    // Line 0, solid red
    hs_lo = 0; n_e0 = 0; n_zero = 0;
    for (int k = 0; k < 800; k++) begin
      tick(1'b1, 1'b0);
      if (hs_a == 1'b0) hs_lo++;
      if (rgb_a == 8'hE0) n_e0++;
      if (rgb_a == 8'h00) n_zero++;
      if (x_a == 10'd656) check("a_hs_before", hs_a, 1);
      if (x_a == 10'd657) check("a_hs_assert", hs_a, 0);
      if (x_a == 10'd752) check("a_hs_last", hs_a, 0);
      if (x_a == 10'd753) check("a_hs_deassert", hs_a, 1);
      if (x_a == 10'd1) check("a_rgb_px0", rgb_a, 8'hE0);
      if (x_a == 10'd641) check("a_rgb_px640", rgb_a, 0);
    end
    check("a_hs_low_count", hs_lo, 96);
    check("a_rgb_e0_count", n_e0, 640);
    check("a_rgb_zero_count", n_zero, 160);
    check("a_line1_x", x_a, 0);
    check("a_line1_y", y_a, 1);
    check("a_line1_ls", ls_a, 1);
    check("a_line1_fs", fs_a, 0);

    // Async reset mid-line at (300,1)
    for (int k = 0; k < 300; k++) tick(1'b1, 1'b0);
    check("a_pre_rst_x", x_a, 300);
    check("a_pre_rst_rgb", rgb_a, 8'hE0);
    rst_a = 1'b0;
    #1;
    check("a_mid_rst_x", x_a, 799);
    check("a_mid_rst_y", y_a, 524);
    check("a_mid_rst_rgb", rgb_a, 0);
    check("a_mid_rst_hs", hs_a, 1);
    check("a_mid_rst_active", act_a, 0);
    check("a_mid_rst_ls", ls_a, 0);
    mode_a = 2'd1;
    rst_a = 1'b1;
    tick(1'b1, 1'b0);
    check("a_restart_fs", fs_a, 1);
    check("a_restart_xy", {x_a, y_a}, 0);

    // Colour bars on line 0, 80 pixels each
    for (int k = 0; k < 641; k++) begin
      tick(1'b1, 1'b0);
      if (k == 640) check("a_bars_blank", rgb_a, 0);
      else if ((k % 80 == 0) || (k % 80 == 79)) check($sformatf("a_bar_x%0d", k), rgb_a, bars[k / 80]);
    end

    // Instance B: whole frame at half strobe rate, mode 0 -> 2 mid-frame
    rst_b = 1'b1;
    tick(1'b0, 1'b1);
    check("b_first_fs", fs_b, 1);
    n = 0; vs_lo = 0; hs_hi = 0; n_solid = 0; n_ls = 0; got_fs = 1'b0;
    while (!got_fs && n < 1000) begin
      tick(1'b0, 1'b0);
      if (n % 97 == 0) begin
        check($sformatf("b_hold_x_n%0d", n), x_b, n % 58);
        check($sformatf("b_hold_y_n%0d", n), y_b, n / 58);
      end
      tick(1'b0, 1'b1);
      n++;
      if (vs_b == 1'b0) vs_lo++;
      if (hs_b == 1'b1) hs_hi++;
      if (rgb_b == 8'h1C) n_solid++;
      if (ls_b == 1'b1) n_ls++;
      if (x_b == 6'd0 && y_b == 4'd3) mode_b = 2'd2;
      if (fs_b == 1'b1) got_fs = 1'b1;
    end
    check("b_frame_strobes", n, 696);
    check("b_vs_low_count", vs_lo, 116);
    check("b_hs_high_count", hs_hi, 96);
    check("b_solid_count", n_solid, 252);
    check("b_line_starts", n_ls, 12);

    // Next frame uses external data, one pixel behind x
    for (int k = 0; k < 58; k++) begin
      tick(1'b0, 1'b1);
      if (k == 1 || k == 20 || k == 41) check($sformatf("b_ext_x%0d", k), rgb_b, k);
      if (k == 42) check("b_ext_blank", rgb_b, 0);
    end

    // Async reset at (20,4) with external data showing
    for (int k = 0; k < 194; k++) tick(1'b0, 1'b1);
    check("b_pre_rst_xy", {x_b, y_b}, {6'd20, 4'd4});
    check("b_pre_rst_rgb", rgb_b, 19);
    rst_b = 1'b0;
    #1;
    check("b_mid_rst_x", x_b, 57);
    check("b_mid_rst_y", y_b, 11);
    check("b_mid_rst_rgb", rgb_b, 0);
    check("b_mid_rst_hs", hs_b, 0);
    check("b_mid_rst_vs", vs_b, 1);
    check("b_mid_rst_fs", fs_b, 0);
    mode_b = 2'd1;
    rst_b = 1'b1;
    tick(1'b0, 1'b1);
    check("b_restart_fs", fs_b, 1);

    // Bars 5 pixels wide; remainder pixels 40,41 stay on bar 7
    for (int k = 0; k < 42; k++) begin
      tick(1'b0, 1'b1);
      idx = (k / 5 > 7) ? 7 : k / 5;
      if (k == 0 || k == 5 || k == 34 || k == 35 || k == 40 || k == 41)
        check($sformatf("b_bar_x%0d", k), rgb_b, bars[idx]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator and pixel output stage. It replaces the fixed 640x480 timing block and the hard-wired colour assignment in the top level. It produces sync, blanking, pixel coordinates and frame/line strobes from a pixel-enable strobe. It drives the RGB pins through a one-pixel pipeline, with a selectable source: solid colour, colour bars or external pixel data.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- HS_POL / VS_POL, 0 / 0, asserted level of hs / vs (0 = active-low)
- XW / YW, 10 / 10, counter widths; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pix_stb  in  1  pixel enable; all state advances only on clk edges where pix_stb=1
- mode  in  2  0 solid, 1 colour bars, 2 external, 3 reserved (outputs black)
- solid_rgb  in  8  {r[2:0],g[2:0],b[1:0]} colour used in mode 0
- ext_rgb  in  8  external pixel colour; must be a combinational function of x/y (mode 2)
- x  out  XW  horizontal counter, stage 0
- y  out  YW  vertical counter, stage 0
- active  out  1  stage-0 pixel lies in the visible area
- line_start  out  1  stage 0, high while x==0
- frame_start  out  1  stage 0, high while x==0 and y==0
- vga_hs, vga_vs  out  1 each  sync outputs, stage 1
- vga_r  out  3  red, stage 1
- vga_g  out  3  green, stage 1
- vga_b  out  2  blue, stage 1

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL computed the same way (default 525).
- Horizontal order: active 0..H_ACTIVE-1, then front porch, sync, back porch. Vertical order is the same, in lines.
- Stage 0 (counters):
  - On pix_stb, x increments. At H_TOTAL-1, x wraps to 0 and y increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
  - active, line_start and frame_start are registered from the next counter values, so they are aligned with x/y.
- Stage 1 (outputs): on pix_stb, the registers take the values decoded from stage 0.
  - vga_hs = HS_POL when x is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~HS_POL. vga_vs is decoded the same way from y.
  - RGB is 0 whenever stage-0 active=0.
  - Otherwise RGB comes from the source selected by mode_q.
- Colour bars: 8 bars, each H_ACTIVE/8 wide (integer division). Any remainder pixels use bar 7.
  - Bar order: white FF, yellow FC, cyan 1F, green 1C, magenta E3, red E0, blue 03, black 00.
- mode_q latches mode only on the pix_stb where stage 0 enters (0,0). Mode changes mid-frame take effect from the next frame.

## Timing
- Reset values (async, while rst=0):
  - x=H_TOTAL-1, y=V_TOTAL-1
  - active=0, line_start=0, frame_start=0
  - vga_hs=~HS_POL, vga_vs=~VS_POL
  - RGB=0, mode_q=0
- First pix_stb after reset release moves stage 0 to (0,0) with frame_start=1. mode_q loads mode on that same edge.
- Latency: RGB, hs and vs lag x/y by exactly one pix_stb. ext_rgb is sampled on the same edge that stage 1 captures.
- pix_stb=0 holds every register. Strobes remain high for the whole pixel period; consumers qualify them with pix_stb.
- Reset asserted mid-frame returns all registers to reset values immediately. The counters restart cleanly, with no partial line.
- Default frame: 420000 pix_stb per frame.
  - hs asserted for 96 consecutive pixels; stage-0 x=656..751 → vga_hs asserted while x=657..752 and at the x=0 following x=752's… (see rule below).
  - Rule: vga_hs follows stage-0 x by one pix_stb. It asserts on the strobe after x=656 and deasserts on the strobe after x=752.
  - vs asserted for 2 lines.

## Structure
- A shared package holds:
  - the mode encodings (MODE_SOLID, MODE_BARS, MODE_EXT)
  - the colour-bar constant array
  - default 640x480@60 timing constants, so further resolutions can add parameter sets there
- One sub-module is natural: vga_axis_counter, instantiated twice.
  - Parameters: ACTIVE, FP, SYNC, BP, POL.
  - Ports: enable, wrap output, count, active flag, sync flag.
  - The vertical instance is enabled by pix_stb and the horizontal wrap.

## Test plan
- Reset then 1 pix_stb → x=0, y=0, frame_start=1, line_start=1, active=1. During reset, RGB=0 and hs=vs=1.
- 800 pix_stb with mode 0, solid_rgb=E0:
  - vga_hs low for exactly 96 strobes, beginning one strobe after x=656.
  - RGB=E0 for 640 strobes and 0 for 160.
- Full frame with pix_stb every 2nd clk → 420000 strobes between frame_start pulses. vs low for 1600 strobes. Counters hold on idle clocks.
- mode 1, line 0 → RGB sequence FF, FC, 1F, 1C, E3, E0, 03, 00, changing at x=80, 160, …, 560 (plus one-pixel lag).
- mode switched 0→2 at y=100 → solid colour continues to end of frame. On the next frame, RGB tracks ext_rgb driven as x[7:0] with one-pixel lag.
- rst pulsed at (x=300, y=200) → all outputs at reset values. The next strobe gives frame_start=1 at (0,0).
